// File: rtl/sprite_drawer_if.sv
// Bundle of request, ROM and VGA-plot signals for the sprite rasteriser.
// The master modport is the drawer; the slave modport is the environment around it.
interface sprite_drawer_if #(
    parameter int n  = 3,
    parameter int Mn = 6,
    parameter int XW = 8,
    parameter int YW = 7
);
    logic          start;
    logic [XW-1:0] x_in;
    logic [YW-1:0] y_in;
    logic          erase;
    logic [Mn-1:0] rom_address;
    logic [n-1:0]  rom_q;
    logic [XW-1:0] vga_x;
    logic [YW-1:0] vga_y;
    logic [n-1:0]  vga_colour;
    logic          plot;
    logic          busy;
    logic          done;

    modport master (
        input  start, x_in, y_in, erase, rom_q,
        output rom_address, vga_x, vga_y, vga_colour, plot, busy, done
    );

    modport slave (
        output start, x_in, y_in, erase, rom_q,
        input  rom_address, vga_x, vga_y, vga_colour, plot, busy, done
    );
endinterface

// File: rtl/sprite_drawer.sv
// Reads a W x H sprite from a synchronous ROM and issues one clipped VGA plot per visible pixel.
// Erase mode paints the background colour over the whole on-screen footprint.
module sprite_drawer #(
    parameter int n           = 3,
    parameter int W           = 8,
    parameter int H           = 8,
    parameter int Mn          = 6,
    parameter int XW          = 8,
    parameter int YW          = 7,
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int TRANSPARENT = 0,
    parameter int BG_COLOUR   = 0
) (
    input logic             clock,
    input logic             reset,
    sprite_drawer_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [Mn-1:0] LAST = Mn'(W*H-1);

    state_t        state_q, state_d;
    logic [Mn-1:0] cnt_q, cnt_d;
    logic [Mn-1:0] idx_q, idx_d;
    logic          vld_q, vld_d;
    logic [XW-1:0] x0_q, x0_d;
    logic [YW-1:0] y0_q, y0_d;
    logic          erase_q, erase_d;
    logic [XW-1:0] vga_x_q, vga_x_d;
    logic [YW-1:0] vga_y_q, vga_y_d;
    logic [n-1:0]  vga_colour_q, vga_colour_d;
    logic          plot_q, plot_d;
    logic [XW:0]   px;
    logic [YW:0]   py;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        vld_d        = 1'b0;
        x0_d         = x0_q;
        y0_d         = y0_q;
        erase_d      = erase_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        plot_d       = 1'b0;
        px           = '0;
        py           = '0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    x0_d    = bus.x_in;
                    y0_d    = bus.y_in;
                    erase_d = bus.erase;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // idx/vld shadow the address the ROM latches so they line up with rom_q
                cnt_d = cnt_q + 1'b1;
                idx_d = cnt_q;
                vld_d = 1'b1;
                if (cnt_q == LAST) state_d = FLUSH;
            end
            FLUSH: begin
                if (!vld_q) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (vld_q) begin
            // one extra bit on each coordinate so off-screen pixels clip rather than wrap
            px           = {1'b0, x0_q} + (XW+1)'(32'(idx_q) % W);
            py           = {1'b0, y0_q} + (YW+1)'(32'(idx_q) / W);
            plot_d       = (erase_q || (bus.rom_q != n'(TRANSPARENT)))
                           && (px < (XW+1)'(SCREEN_W)) && (py < (YW+1)'(SCREEN_H));
            vga_x_d      = px[XW-1:0];
            vga_y_d      = py[YW-1:0];
            vga_colour_d = erase_q ? n'(BG_COLOUR) : bus.rom_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            vld_q        <= 1'b0;
            x0_q         <= '0;
            y0_q         <= '0;
            erase_q      <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            plot_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            vld_q        <= vld_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            erase_q      <= erase_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            plot_q       <= plot_d;
        end
    end

    assign bus.rom_address = cnt_q;
    assign bus.vga_x       = vga_x_q;
    assign bus.vga_y       = vga_y_q;
    assign bus.vga_colour  = vga_colour_q;
    assign bus.plot        = plot_q;
    assign bus.busy        = (state_q == RUN) || (state_q == FLUSH);
    assign bus.done        = (state_q == DONE);
endmodule

// File: tb/tb_sprite_drawer.sv
// Self-checking bench for sprite_drawer: a scoreboard of expected plots (position, colour, cycle)
// is filled when each sprite is started and drained as the DUT plots.
module tb_sprite_drawer;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    sprite_drawer_if bus();

    sprite_drawer dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Synchronous object ROM holding colour(a) = a[2:0]
    always @(posedge clock) bus.rom_q <= bus.rom_address[2:0];

    typedef struct {
        int x;
        int y;
        int c;
        int cyc;
    } pix_t;

    pix_t sb[$];
    pix_t e;
    int   cyc            = 0;
    int   assert_count   = 0;
    int   fail_count     = 0;
    int   plot_total     = 0;
    int   c0             = 0;
    int   exp_plots      = 0;
    int   plots_at_start = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Caller is at a negedge; start is sampled at the next posedge (E0)
    task automatic applyStimulus(input int x, input int y, input bit er);
        bus.start = 1'b1;
        bus.x_in  = 8'(x);
        bus.y_in  = 7'(y);
        bus.erase = er;
        @(posedge clock);
        #1;
        bus.start      = 1'b0;
        c0             = cyc;
        plots_at_start = plot_total;
        exp_plots      = 0;
        for (int k = 0; k < 64; k++) begin
            int col, row, px, py, c;
            col = k % 8;
            row = k / 8;
            px  = x + col;
            py  = y + row;
            c   = er ? 0 : (k % 8);
            if ((er || c != 0) && px < 160 && py < 120) begin
                sb.push_back('{px, py, c, c0 + k + 2});
                exp_plots++;
            end
        end
    endtask

    // Waits (bounded) for done, checks latency/width/plot count; optionally pokes start during done
    task automatic finishSprite(input string name, input bit poke_start);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clock);
            if (bus.done) seen = 1'b1;
        end
        checkOutput({name, "_done_seen"}, int'(bus.done), 1);
        checkOutput({name, "_done_latency"}, cyc - c0, 66);
        checkOutput({name, "_busy_at_done"}, int'(bus.busy), 0);
        checkOutput({name, "_plot_count"}, plot_total - plots_at_start, exp_plots);
        checkOutput({name, "_sb_drained"}, sb.size(), 0);
        if (poke_start) begin
            bus.start = 1'b1;
            bus.x_in  = 8'd100;
            bus.y_in  = 7'd100;
            @(posedge clock);
            #1;
            bus.start = 1'b0;
        end
        @(negedge clock);
        checkOutput({name, "_done_width"}, int'(bus.done), 0);
        checkOutput({name, "_idle_after_done"}, int'(bus.busy), 0);
    endtask

    always @(negedge clock) begin
        if (!reset && bus.plot) begin
            plot_total++;
            if (sb.size() == 0) begin
                checkOutput("spurious_plot", int'(bus.plot), 0);
            end else begin
                e = sb.pop_front();
                checkOutput("plot_x", int'(bus.vga_x), e.x);
                checkOutput("plot_y", int'(bus.vga_y), e.y);
                checkOutput("plot_colour", int'(bus.vga_colour), e.c);
                checkOutput("plot_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        bit saw_done;
        bus.start = 1'b0;
        bus.x_in  = '0;
        bus.y_in  = '0;
        bus.erase = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("rst_rom_address", int'(bus.rom_address), 0);
        checkOutput("rst_vga_x", int'(bus.vga_x), 0);
        checkOutput("rst_vga_y", int'(bus.vga_y), 0);
        checkOutput("rst_vga_colour", int'(bus.vga_colour), 0);
        checkOutput("rst_plot", int'(bus.plot), 0);
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_done", int'(bus.done), 0);
        reset = 1'b0;

        @(negedge clock);
        applyStimulus(10, 20, 1'b0);
        @(negedge clock);
        checkOutput("draw_busy", int'(bus.busy), 1);
        finishSprite("draw", 1'b0);

        @(negedge clock);
        applyStimulus(10, 20, 1'b1);
        finishSprite("erase", 1'b0);

        @(negedge clock);
        applyStimulus(156, 116, 1'b0);
        finishSprite("clip", 1'b0);

        @(negedge clock);
        applyStimulus(10, 20, 1'b0);
        repeat (4) @(negedge clock);
        bus.start = 1'b1;
        bus.x_in  = 8'd50;
        bus.y_in  = 7'd50;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        finishSprite("restart_ignored", 1'b0);

        // start during done is ignored; the next IDLE cycle accepts a back-to-back draw
        @(negedge clock);
        applyStimulus(30, 40, 1'b0);
        finishSprite("pre_b2b", 1'b1);
        applyStimulus(140, 100, 1'b0);
        @(negedge clock);
        checkOutput("b2b_busy", int'(bus.busy), 1);
        finishSprite("b2b", 1'b0);

        @(negedge clock);
        applyStimulus(10, 20, 1'b0);
        repeat (19) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        sb.delete();
        @(negedge clock);
        checkOutput("midrst_plot", int'(bus.plot), 0);
        checkOutput("midrst_busy", int'(bus.busy), 0);
        checkOutput("midrst_done", int'(bus.done), 0);
        reset    = 1'b0;
        saw_done = 1'b0;
        repeat (80) begin
            @(negedge clock);
            if (bus.done) saw_done = 1'b1;
        end
        checkOutput("midrst_no_done", int'(saw_done), 0);
        applyStimulus(0, 0, 1'b0);
        finishSprite("after_reset", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
